hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It produces the stall and clear controls for the PC register, the IF/ID register and the ID/EX register, plus the forwarding-mux selects. It also sequences the multi-cycle multiply/divide unit through an internal busy counter. It sits beside the datapath, takes register numbers and control bits from the D, E, M and W stages, and contains no datapath storage of its own.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller and mult/div sequencer for the 5-stage MIPS core.
// Define HAZARD_PERF_EN to add the 32-bit stall_cnt performance counter.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic       mdstartD,
  input  logic       mdstartE,
  input  logic       mdopE,
  input  logic       mfhiloD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdbusy,
  output logic       md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lwstall, branchstall, mdstall, stall;
  logic             rsD_hit_e, rtD_hit_e, rsD_hit_m, rtD_hit_m;

  always_comb begin
    forwardAE = 2'b00;
    if (regwriteM && writeregM != 5'd0 && writeregM == rsE)      forwardAE = 2'b10;
    else if (regwriteW && writeregW != 5'd0 && writeregW == rsE) forwardAE = 2'b01;

    forwardBE = 2'b00;
    if (regwriteM && writeregM != 5'd0 && writeregM == rtE)      forwardBE = 2'b10;
    else if (regwriteW && writeregW != 5'd0 && writeregW == rtE) forwardBE = 2'b01;

    forwardAD = regwriteM && writeregM != 5'd0 && writeregM == rsD;
    forwardBD = regwriteM && writeregM != 5'd0 && writeregM == rtD;
  end

  always_comb begin
    rsD_hit_e   = rsD != 5'd0 && writeregE == rsD;
    rtD_hit_e   = rtD != 5'd0 && writeregE == rtD;
    rsD_hit_m   = rsD != 5'd0 && writeregM == rsD;
    rtD_hit_m   = rtD != 5'd0 && writeregM == rtD;
    lwstall     = memtoregE && writeregE != 5'd0 && (writeregE == rsD || writeregE == rtD);
    branchstall = branchD && ((regwriteE && (rsD_hit_e || rtD_hit_e)) ||
                              (memtoregM && (rsD_hit_m || rtD_hit_m)));
    mdstall     = (mdbusy || mdstartE) && (mdstartD || mfhiloD);
    stall       = lwstall | branchstall | mdstall;
    stallF      = stall;
    stallD      = stall;
    flushE      = stall;
    // IF/ID clear beats its hold, so a redirect from a stalled branch must be masked.
    flushD      = pcsrcD && !stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdbusy  = (state_q == BUSY);
    md_done = (state_q == BUSY) && (cnt_q == '0);
    case (state_q)
      IDLE: begin
        if (mdstartE) begin
          cnt_d   = mdopE ? DIV_LD : MUL_LD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A start arriving while busy is ignored; mdstall normally keeps it in D.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle compare against a rule-level model
// plus hand-computed literal checks for the documented scenarios.
module tb_hazard_ctrl;
  localparam int MUL = 5;
  localparam int DIV = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, pcsrcD, mdstartD, mdstartE, mdopE, mfhiloD;
  logic       stallF, stallD, flushD, flushE, forwardAD, forwardBD, mdbusy, md_done;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_cnt = 32'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int mdrem   = 0;   // model: busy cycles still to run

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .pcsrcD(pcsrcD),
    .mdstartD(mdstartD), .mdstartE(mdstartE), .mdopE(mdopE), .mfhiloD(mfhiloD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .mdbusy(mdbusy), .md_done(md_done)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] w, input logic [4:0] r);
    return (w != 5'd0) && (w == r);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (regwriteM && hit(writeregM, r)) return 2'b10;
    if (regwriteW && hit(writeregW, r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    bit lw, br, md;
    lw = memtoregE && (hit(writeregE, rsD) || hit(writeregE, rtD));
    br = branchD && ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                     (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
    md = (mdrem > 0 || mdstartE) && (mdstartD || mfhiloD);
    return lw | br | md;
  endfunction

  always @(posedge clk) begin
`ifdef HAZARD_PERF_EN
    if (rst) m_cnt <= 32'd0;
    else if (exp_stall()) m_cnt <= m_cnt + 32'd1;
`endif
    if (rst)            mdrem <= 0;
    else if (mdrem > 0) mdrem <= mdrem - 1;
    else if (mdstartE)  mdrem <= mdopE ? DIV : MUL;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit s;
      s = exp_stall();
      chk("m_stallF", stallF, s);
      chk("m_stallD", stallD, s);
      chk("m_flushE", flushE, s);
      chk("m_flushD", flushD, pcsrcD && !s);
      chk("m_fwdAE", forwardAE, fwd_e(rsE));
      chk("m_fwdBE", forwardBE, fwd_e(rtE));
      chk("m_fwdAD", forwardAD, regwriteM && hit(writeregM, rsD));
      chk("m_fwdBD", forwardBD, regwriteM && hit(writeregM, rtD));
      chk("m_mdbusy", mdbusy, mdrem > 0);
      chk("m_md_done", md_done, mdrem == 1);
`ifdef HAZARD_PERF_EN
      chk("m_stall_cnt", stall_cnt, m_cnt);
`endif
    end
  end

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, pcsrcD, mdstartD, mdstartE, mdopE, mfhiloD} = '0;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) adv();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mdbusy", mdbusy, 1'b0);
    chk("rst_md_done", md_done, 1'b0);
    adv(); rst = 1'b0;

    // load-use, with a concurrent redirect that must be masked
    memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; pcsrcD = 1;
    @(negedge clk);
    chk("lw_stallF", stallF, 1'b1);
    chk("lw_stallD", stallD, 1'b1);
    chk("lw_flushE", flushE, 1'b1);
    chk("lw_flushD", flushD, 1'b0);
    adv(); writeregE = 0;
    @(negedge clk);
    chk("lw0_stallF", stallF, 1'b0);
    chk("lw0_flushE", flushE, 1'b0);
    chk("lw0_flushD", flushD, 1'b1);

    // forwarding priority
    adv(); clr(); rsE = 5; regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5;
    rtE = 5; rsD = 5;
    @(negedge clk);
    chk("fwd_AE_M", forwardAE, 2'b10);
    chk("fwd_BE_M", forwardBE, 2'b10);
    chk("fwd_AD", forwardAD, 1'b1);
    chk("fwd_BD", forwardBD, 1'b0);
    adv(); regwriteM = 0;
    @(negedge clk);
    chk("fwd_AE_W", forwardAE, 2'b01);
    chk("fwd_AD_off", forwardAD, 1'b0);
    adv(); rsE = 0; writeregW = 0; regwriteM = 1; writeregM = 0;
    @(negedge clk);
    chk("fwd_AE_r0", forwardAE, 2'b00);

    // branch hazard from E, then re-resolve
    adv(); clr(); branchD = 1; rtD = 3; regwriteE = 1; writeregE = 3; pcsrcD = 1;
    @(negedge clk);
    chk("br_stall", stallF, 1'b1);
    chk("br_flushD", flushD, 1'b0);
    adv(); regwriteE = 0; writeregE = 0;
    @(negedge clk);
    chk("br2_stall", stallF, 1'b0);
    chk("br2_flushD", flushD, 1'b1);
    adv(); clr(); branchD = 1; rsD = 7; memtoregM = 1; writeregM = 7;
    @(negedge clk);
    chk("brM_stall", stallD, 1'b1);

    // multiply with mfhi waiting in D
    adv(); clr(); mdstartE = 1; mdopE = 0; mfhiloD = 1;
    @(negedge clk);
    chk("mul_c0_stall", stallF, 1'b1);
    chk("mul_c0_busy", mdbusy, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      adv(); mdstartE = 0;
      @(negedge clk);
      chk($sformatf("mul_c%0d_busy", c), mdbusy, c <= 5);
      chk($sformatf("mul_c%0d_done", c), md_done, c == 5);
      chk($sformatf("mul_c%0d_stall", c), stallF, c <= 5);
    end

    // divide abandoned by reset in cycle 10
    adv(); clr(); mdstartE = 1; mdopE = 1;
    adv(); mdstartE = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("div_c%0d_busy", c), mdbusy, 1'b1);
      if (c < 10) adv();
    end
    rst = 1'b1;
    adv(); rst = 1'b0;
    @(negedge clk);
    chk("div_rst_busy", mdbusy, 1'b0);
    chk("div_rst_done", md_done, 1'b0);
    repeat (3) adv();
    mdstartE = 1; mdopE = 0;
    adv(); mdstartE = 0;
    @(negedge clk);
    chk("restart_busy", mdbusy, 1'b1);
    repeat (6) adv();
    @(negedge clk);
    chk("restart_idle", mdbusy, 1'b0);

`ifdef HAZARD_PERF_EN
    rst = 1'b1;
    adv(); rst = 1'b0;
    memtoregE = 1; writeregE = 4; rsD = 4;
    repeat (7) adv();
    clr();
    @(negedge clk);
    chk("perf_cnt7", stall_cnt, 32'd7);
`endif

    adv();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
